// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcode and state encodings for the EX-stage divider.
package riscv_pkg;
   typedef enum logic [1:0] {DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU} div_op_e;
   typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_e;
endpackage

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring RV32M divider that stalls the pipeline while it runs.
module div_unit
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            ex_stall,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN);
   div_state_e state, state_n;
   div_op_e op_q;
   logic [CW-1:0] count;
   logic [XLEN:0] rem, shifted, diff;
   logic [XLEN-1:0] quot, divisor, a_abs, b_abs, special_res, q_step, r_step, fix_res;
   logic neg_q, neg_r, is_signed, b_zero, ovf, special, q_bit, accept;
   always_comb begin
      is_signed   = ~op[0];
      b_zero      = operand_b == '0;
      ovf         = is_signed && operand_a == {1'b1, {(XLEN-1){1'b0}}} && operand_b == '1;
      special     = b_zero || ovf;
      special_res = b_zero ? (op[1] ? operand_a : '1) : (op[1] ? '0 : operand_a);
      a_abs       = (is_signed && operand_a[XLEN-1]) ? -operand_a : operand_a;
      b_abs       = (is_signed && operand_b[XLEN-1]) ? -operand_b : operand_b;
      accept      = state == DIV_IDLE && start && !flush;
      // The dividend is shifted out of quot's top while quotient bits enter at the bottom.
      shifted     = {rem[XLEN-1:0], quot[XLEN-1]};
      diff        = shifted - {1'b0, divisor};
      q_bit       = ~diff[XLEN];
      q_step      = {quot[XLEN-2:0], q_bit};
      r_step      = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      fix_res     = (op_q == DIV_OP_REM || op_q == DIV_OP_REMU) ? (neg_r ? -r_step : r_step)
                                                                : (neg_q ? -q_step : q_step);
   end
   always_comb begin
      state_n  = state;
      ex_stall = !flush && ((state == DIV_IDLE && start) || state == DIV_CALC);
      done     = !flush && state == DIV_DONE;
      if (flush) state_n = DIV_IDLE;
      else if (state == DIV_IDLE) state_n = start ? (special ? DIV_DONE : DIV_CALC) : DIV_IDLE;
      else if (state == DIV_CALC) state_n = (count == '0) ? DIV_DONE : DIV_CALC;
      else state_n = DIV_IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= DIV_IDLE;
         op_q    <= DIV_OP_DIV;
         count   <= '0;
         rem     <= '0;
         quot    <= '0;
         divisor <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         result  <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            op_q    <= div_op_e'(op);
            neg_q   <= is_signed && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
            neg_r   <= is_signed && operand_a[XLEN-1];
            quot    <= a_abs;
            divisor <= b_abs;
            rem     <= '0;
            count   <= CW'(XLEN - 1);
            if (special) result <= special_res;
         end else if (state == DIV_CALC && !flush) begin
            rem   <= {1'b0, r_step};
            quot  <= q_step;
            count <= count - CW'(1);
            if (count == '0) result <= fix_res;
         end
      end
   end
endmodule
